// File: rtl/brch_redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller: control encodings,
// FSM state type and statistics counter width.
package brch_redirect_ctrl_pkg;

    localparam int unsigned CntWidth = 16;
    localparam int unsigned PcWidth  = 16;

    localparam logic [3:0] BrchBeqz = 4'd4;
    localparam logic [3:0] BrchBnez = 4'd5;
    localparam logic [3:0] BrchBltz = 4'd6;
    localparam logic [3:0] BrchBgez = 4'd7;
    localparam logic [3:0] BrchJump = 4'd8;

    typedef enum logic [1:0] {
        StIdle,
        StRedirect,
        StFlush
    } brch_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (v == {CntWidth{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/brch_cond_eval.sv
// Combinational decode of the branch control code against the ALU flags.
module brch_cond_eval
    import brch_redirect_ctrl_pkg::*;
(
    input  logic [3:0] BrchCtrl,
    input  logic       SF,
    input  logic       ZF,
    input  logic       OF,
    output logic       Taken,
    output logic       IsBrch,
    output logic       Illegal
);

    always_comb begin
        Taken   = 1'b0;
        IsBrch  = 1'b0;
        Illegal = 1'b0;
        unique case (BrchCtrl)
            BrchBeqz: begin IsBrch = 1'b1; Taken = ZF;          end
            BrchBnez: begin IsBrch = 1'b1; Taken = ~ZF;         end
            BrchBltz: begin IsBrch = 1'b1; Taken = SF ^ OF;     end
            BrchBgez: begin IsBrch = 1'b1; Taken = ~(SF ^ OF);  end
            BrchJump: begin IsBrch = 1'b1; Taken = 1'b1;        end
            4'd0, 4'd1, 4'd2, 4'd3: ;
            default:  Illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/brch_redirect_ctrl.sv
// Branch redirect controller: accepts resolved EX branches, drives PC redirect
// and pipeline flushes for two cycles, and keeps saturating branch statistics.
module brch_redirect_ctrl
    import brch_redirect_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                ExValid,
    input  logic [3:0]          BrchCtrl,
    input  logic                SF,
    input  logic                ZF,
    input  logic                OF,
    input  logic [PcWidth-1:0]  BrchTarget,
    input  logic                Stall,
    input  logic                CntClr,
    output logic                RedirectVld,
    output logic [PcWidth-1:0]  RedirectPC,
    output logic                FlushIFID,
    output logic                FlushIDEX,
    output logic                IllegalCtrl,
    output logic [CntWidth-1:0] BrchCnt,
    output logic [CntWidth-1:0] TakenCnt
);

    brch_state_e         state_q, state_d;
    logic [PcWidth-1:0]  pc_q, pc_d;
    logic [CntWidth-1:0] brch_cnt_q, brch_cnt_d;
    logic [CntWidth-1:0] taken_cnt_q, taken_cnt_d;
    logic                illegal_q, illegal_d;

    logic taken;
    logic is_brch;
    logic illegal;
    logic accept;

    brch_cond_eval u_cond_eval (
        .BrchCtrl (BrchCtrl),
        .SF       (SF),
        .ZF       (ZF),
        .OF       (OF),
        .Taken    (taken),
        .IsBrch   (is_brch),
        .Illegal  (illegal)
    );

    // Instructions arriving during a redirect window are already squashed.
    assign accept = ExValid && !Stall && (state_q == StIdle);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (accept && taken) state_d = StRedirect;
            StRedirect: if (!Stall)          state_d = StFlush;
            StFlush:    if (!Stall)          state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        illegal_d   = illegal_q;
        brch_cnt_d  = brch_cnt_q;
        taken_cnt_d = taken_cnt_q;

        if (accept && taken) begin
            pc_d = BrchTarget;
        end

        if (!Stall) begin
            illegal_d = accept && illegal;
        end

        // Clear wins over both increment and stall.
        if (CntClr) begin
            brch_cnt_d  = '0;
            taken_cnt_d = '0;
        end else if (accept && is_brch) begin
            brch_cnt_d = sat_inc(brch_cnt_q);
            if (taken) begin
                taken_cnt_d = sat_inc(taken_cnt_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            illegal_q   <= 1'b0;
            brch_cnt_q  <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            illegal_q   <= illegal_d;
            brch_cnt_q  <= brch_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    always_comb begin
        RedirectVld = 1'b0;
        FlushIFID   = 1'b0;
        FlushIDEX   = 1'b0;
        unique case (state_q)
            StRedirect: begin
                RedirectVld = 1'b1;
                FlushIFID   = 1'b1;
                FlushIDEX   = 1'b1;
            end
            StFlush: FlushIFID = 1'b1;
            default: ;
        endcase
    end

    assign RedirectPC  = pc_q;
    assign IllegalCtrl = illegal_q;
    assign BrchCnt     = brch_cnt_q;
    assign TakenCnt    = taken_cnt_q;

endmodule

// File: tb/tb_brch_redirect_ctrl.sv
// Scoreboard bench for brch_redirect_ctrl: a behavioural model predicts every
// cycle's outputs, a monitor compares them against the DUT one cycle later.
module tb_brch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ExValid = 1'b0;
    logic [3:0]  BrchCtrl = 4'd0;
    logic        SF = 1'b0;
    logic        ZF = 1'b0;
    logic        OF = 1'b0;
    logic [15:0] BrchTarget = 16'h0;
    logic        Stall = 1'b0;
    logic        CntClr = 1'b0;
    logic        RedirectVld;
    logic [15:0] RedirectPC;
    logic        FlushIFID;
    logic        FlushIDEX;
    logic        IllegalCtrl;
    logic [15:0] BrchCnt;
    logic [15:0] TakenCnt;

    always #5 clk = ~clk;

    brch_redirect_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ExValid     (ExValid),
        .BrchCtrl    (BrchCtrl),
        .SF          (SF),
        .ZF          (ZF),
        .OF          (OF),
        .BrchTarget  (BrchTarget),
        .Stall       (Stall),
        .CntClr      (CntClr),
        .RedirectVld (RedirectVld),
        .RedirectPC  (RedirectPC),
        .FlushIFID   (FlushIFID),
        .FlushIDEX   (FlushIDEX),
        .IllegalCtrl (IllegalCtrl),
        .BrchCnt     (BrchCnt),
        .TakenCnt    (TakenCnt)
    );

    typedef struct {
        bit        vld;
        bit        ifid;
        bit        idex;
        bit        ill;
        bit [15:0] pc;
        int        bc;
        int        tc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Model state: cycles left in the redirect window (2 = redirect, 1 = flush).
    int        m_window = 0;
    bit        m_ill    = 0;
    bit [15:0] m_pc     = 0;
    int        m_bc     = 0;
    int        m_tc     = 0;

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic drv(input bit r, input bit ev, input logic [3:0] c, input bit sf,
                       input bit zf, input bit of, input logic [15:0] t, input bit st,
                       input bit cl);
        bit   tk;
        bit   br;
        bit   acc;
        exp_t e;
        @(negedge clk);
        rst = r; ExValid = ev; BrchCtrl = c; SF = sf; ZF = zf; OF = of;
        BrchTarget = t; Stall = st; CntClr = cl;
        br = (c >= 4 && c <= 8);
        case (c)
            4'd4:    tk = zf;
            4'd5:    tk = !zf;
            4'd6:    tk = sf ^ of;
            4'd7:    tk = !(sf ^ of);
            4'd8:    tk = 1'b1;
            default: tk = 1'b0;
        endcase
        if (r) begin
            m_window = 0; m_ill = 0; m_pc = 0; m_bc = 0; m_tc = 0;
        end else begin
            acc = ev && !st && (m_window == 0);
            if (!st) begin
                m_ill = acc && (c >= 9);
                if (m_window > 0) m_window = m_window - 1;
                else if (acc && tk) m_window = 2;
                if (acc && tk) m_pc = t;
                if (acc && br) begin
                    m_bc = sat(m_bc + 1);
                    if (tk) m_tc = sat(m_tc + 1);
                end
            end
            if (cl) begin
                m_bc = 0; m_tc = 0;
            end
        end
        e.vld  = (m_window == 2);
        e.ifid = (m_window > 0);
        e.idex = (m_window == 2);
        e.ill  = m_ill;
        e.pc   = m_pc;
        e.bc   = m_bc;
        e.tc   = m_tc;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 4'd0, 0, 0, 0, 16'h0, 0, 0);
    endtask

    function automatic void chk(input string nm, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL cycle %0d %s: got 0x%0h, expected 0x%0h", cyc, nm, act, req);
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("RedirectVld", int'(RedirectVld), int'(e.vld));
                chk("FlushIFID",   int'(FlushIFID),   int'(e.ifid));
                chk("FlushIDEX",   int'(FlushIDEX),   int'(e.idex));
                chk("IllegalCtrl", int'(IllegalCtrl), int'(e.ill));
                chk("RedirectPC",  int'(RedirectPC),  int'(e.pc));
                chk("BrchCnt",     int'(BrchCnt),     e.bc);
                chk("TakenCnt",    int'(TakenCnt),    e.tc);
            end
        end
    end

    initial begin : stimulus
        int wait_cyc;
        for (int i = 0; i < 3; i++) drv(1, 1, 4'd8, 0, 0, 0, 16'hffff, 1, 1);

        // Taken BEQZ, then not-taken BNEZ.
        drv(0, 1, 4'd4, 0, 1, 0, 16'h0040, 0, 0);
        idle(3);
        drv(0, 1, 4'd5, 0, 1, 0, 16'h0bad, 0, 0);
        idle(2);

        // JUMP then stall in REDIRECT with a BLTZ presented throughout.
        drv(0, 1, 4'd8, 0, 0, 0, 16'h1234, 0, 0);
        for (int i = 0; i < 3; i++) drv(0, 1, 4'd6, 1, 0, 0, 16'h5555, 1, 0);
        drv(0, 1, 4'd6, 1, 0, 0, 16'h6666, 0, 0);
        drv(0, 1, 4'd6, 1, 0, 0, 16'h7777, 0, 0);
        idle(2);

        // Illegal code, compare ops, deferred acceptance under stall.
        drv(0, 1, 4'hc, 0, 0, 0, 16'h9999, 0, 0);
        idle(2);
        for (int c = 0; c < 4; c++) drv(0, 1, 4'(c), 1, 1, 0, 16'h2222, 0, 0);
        drv(0, 1, 4'd7, 0, 0, 0, 16'h3333, 1, 0);
        drv(0, 1, 4'd7, 0, 0, 0, 16'h3333, 1, 0);
        drv(0, 1, 4'd7, 0, 0, 0, 16'h3334, 0, 0);
        idle(3);

        // Reset during FLUSH.
        drv(0, 1, 4'd8, 0, 0, 0, 16'habcd, 0, 0);
        idle(1);
        drv(1, 1, 4'd8, 0, 0, 0, 16'h1111, 1, 0);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drv(($urandom_range(99) == 0), ($urandom_range(3) != 0),
                4'($urandom_range(15)), 1'($urandom), 1'($urandom), 1'($urandom),
                16'($urandom), ($urandom_range(3) == 0), ($urandom_range(49) == 0));
        end

        // Saturation: not-taken BNEZ bumps only BrchCnt, one per cycle.
        drv(1, 0, 4'd0, 0, 0, 0, 16'h0, 0, 0);
        for (int i = 0; i < 65540; i++) drv(0, 1, 4'd5, 0, 1, 0, 16'h0, 0, 0);
        drv(0, 1, 4'd8, 0, 0, 0, 16'h4242, 0, 0);
        idle(2);
        drv(0, 1, 4'd8, 0, 0, 0, 16'h4343, 0, 1);
        idle(3);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
